// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : CAS-latency encodings and read-alignment depth for the DQ PHY.
// Revision : 1.0
// ============================================================================
package sdram_pkg;

  localparam int C_CL_MIN         = 2;
  localparam int C_CL_LIMIT       = 7;
  // Command-register cycle plus capture-register cycle around the CAS latency
  localparam int C_ALIGN_OVERHEAD = 2;
  localparam int C_ALIGN_DEPTH_DEF = 3 + C_ALIGN_OVERHEAD;

  typedef enum logic [2:0] {
    CAS_2 = 3'd2,
    CAS_3 = 3'd3,
    CAS_4 = 3'd4,
    CAS_5 = 3'd5,
    CAS_6 = 3'd6,
    CAS_7 = 3'd7
  } cas_e;

  function automatic int align_depth(input int cl_max, input int cap_stages);
    return cl_max + C_ALIGN_OVERHEAD + cap_stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_dq_phy_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_dq_phy_if
// Brief    : Controller-side write/read beat bus of the SDRAM DQ PHY.
// Revision : 1.0
// ============================================================================
interface sdram_dq_phy_if #(
  parameter int W   = 16,
  parameter int CLW = 2
);

  logic [W-1:0]   w_data;
  logic           w_en;
  logic           rd_issue;
  logic [CLW-1:0] cas_latency;
  logic [W-1:0]   r_data;
  logic           r_valid;
  logic           rd_busy;
  logic           err_contention;

  modport master (
    output w_data, w_en, rd_issue, cas_latency,
    input  r_data, r_valid, rd_busy, err_contention
  );

  modport slave (
    input  w_data, w_en, rd_issue, cas_latency,
    output r_data, r_valid, rd_busy, err_contention
  );

endinterface
`default_nettype wire

// File: rtl/sdram_rd_align.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rd_align
// Brief    : One-hot-insertion shift register that times read beats to pads.
// Revision : 1.0
// ============================================================================
module sdram_rd_align
  import sdram_pkg::*;
#(
  parameter int CL_MAX     = 3,
  parameter int CAP_STAGES = 0,
  parameter int CLW        = $clog2(CL_MAX + 1)
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           rd_issue,
  input  wire logic [CLW-1:0] cas_latency,
  output logic                pad_slot_nxt,
  output logic                rd_valid,
  output logic                busy
);

  localparam int DEPTH = align_depth(CL_MAX, CAP_STAGES);

  logic [DEPTH-1:0] r_align;
  logic [DEPTH-1:0] w_ins;
  logic             w_cl_ok;

  // Bit 0 is the r_valid cycle; a beat with latency L enters at L+1+CAP_STAGES.
  // Unsupported latencies fall back to the CL_MAX slot.
  always_comb begin
    w_ins   = '0;
    w_cl_ok = 1'b0;
    for (int l = C_CL_MIN; l <= CL_MAX; l++) begin
      if (cas_latency == CLW'(l)) begin
        w_ins[l + 1 + CAP_STAGES] = rd_issue;
        w_cl_ok                   = 1'b1;
      end
    end
    if (!w_cl_ok) begin
      w_ins[CL_MAX + 1 + CAP_STAGES] = rd_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align <= '0;
    end else begin
      r_align <= {1'b0, r_align[DEPTH-1:1]} | w_ins;
    end
  end

  // Bit CAP_STAGES+1 marks the current pad-read slot, so the next one sits above it
  assign pad_slot_nxt = r_align[CAP_STAGES + 2];
  assign rd_valid     = r_align[0];
  assign busy         = rd_issue | (|r_align);

endmodule
`default_nettype wire

// File: rtl/sdram_dq_phy.sv
`default_nettype none
// ============================================================================
// Module   : sdram_dq_phy
// Brief    : SDRAM DQ pad PHY: registered write drive, read capture/alignment.
// Revision : 1.0
// ============================================================================
module sdram_dq_phy
  import sdram_pkg::*;
#(
  parameter int W          = 16,
  parameter int CL_MAX     = 3,
  parameter int CAP_STAGES = 0,
  parameter int CLW        = $clog2(CL_MAX + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sdram_dq_phy_if.slave     bus,
  inout  wire [W-1:0]       dq
);

  logic [W-1:0]                r_dout;
  logic                        r_oe;
  logic                        r_err;
  logic [W-1:0]                w_din;
  logic [CAP_STAGES:0][W-1:0]  r_cap;
  logic [W-1:0]                r_hold;
  logic                        w_slot_nxt;
  logic                        w_valid;
  logic                        w_busy;

  sdram_rd_align #(
    .CL_MAX     (CL_MAX),
    .CAP_STAGES (CAP_STAGES),
    .CLW        (CLW)
  ) u_align (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_issue     (bus.rd_issue),
    .cas_latency  (bus.cas_latency),
    .pad_slot_nxt (w_slot_nxt),
    .rd_valid     (w_valid),
    .busy         (w_busy)
  );

  // A write landing on a pad-read slot keeps its data but never enables the pads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_oe   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_dout <= bus.w_data;
      r_oe   <= bus.w_en & ~w_slot_nxt;
      r_err  <= bus.w_en & w_slot_nxt;
    end
  end

`ifdef FPGA_ECP5
  for (genvar i = 0; i < W; i++) begin : g_pad
    BB u_bb (
      .I (r_dout[i]),
      .T (~r_oe),
      .O (w_din[i]),
      .B (dq[i])
    );
  end
`else
  assign dq    = r_oe ? r_dout : {W{1'bz}};
  assign w_din = dq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap <= '0;
    end else begin
      r_cap[0] <= w_din;
      for (int i = 1; i <= CAP_STAGES; i++) begin
        r_cap[i] <= r_cap[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_valid) begin
      r_hold <= r_cap[CAP_STAGES];
    end
  end

  assign bus.r_valid        = w_valid;
  assign bus.r_data         = w_valid ? r_cap[CAP_STAGES] : r_hold;
  assign bus.rd_busy        = w_busy;
  assign bus.err_contention = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_dq_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_dq_phy
// Brief    : Directed self-checking bench for sdram_dq_phy (W=16, CL_MAX=3).
// Revision : 1.0
// ============================================================================
module tb_sdram_dq_phy;

  localparam int W          = 16;
  localparam int CL_MAX     = 3;
  localparam int CAP_STAGES = 0;
  localparam int CLW        = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dev_oe;
  logic [W-1:0] dev_data;
  wire  [W-1:0] dq;
  int           tests = 0;
  int           fails = 0;

  sdram_dq_phy_if #(.W(W), .CLW(CLW)) bus ();

  sdram_dq_phy #(
    .W          (W),
    .CL_MAX     (CL_MAX),
    .CAP_STAGES (CAP_STAGES),
    .CLW        (CLW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dq    (dq)
  );

  assign dq = dev_oe ? dev_data : {W{1'bz}};

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; outputs are read 2 units later.
  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.w_en        = 1'b0;
    bus.w_data      = '0;
    bus.rd_issue    = 1'b0;
    bus.cas_latency = 2'd2;
    dev_oe          = 1'b0;
    dev_data        = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      start_cycle();
      settle();
      tests++;
      if ({bus.r_valid, bus.rd_busy, bus.err_contention, dut.r_oe} !== 4'b0000) begin
        fails++;
        $display("FAIL rst_flags: got valid/busy/err/oe=%b required 0000",
                 {bus.r_valid, bus.rd_busy, bus.err_contention, dut.r_oe});
      end
      tests++;
      if (bus.r_data !== 16'h0000) begin
        fails++;
        $display("FAIL rst_rdata: got %h required 0000", bus.r_data);
      end
    end
    // Release and issue traffic in the very first cycle out of reset
    for (int c = 0; c < 6; c++) begin
      start_cycle();
      clear_inputs();
      if (c == 0) begin
        rst_n           = 1'b1;
        bus.w_en        = 1'b1;
        bus.w_data      = 16'h0F0F;
        bus.rd_issue    = 1'b1;
        bus.cas_latency = 2'd2;
      end
      if (c == 3) begin
        dev_oe   = 1'b1;
        dev_data = 16'h00FF;
      end
      settle();
      if (c == 1) begin
        tests++;
        if (dut.r_oe !== 1'b1 || dq !== 16'h0F0F) begin
          fails++;
          $display("FAIL first_write: got oe=%b dq=%h required oe=1 dq=0f0f", dut.r_oe, dq);
        end
      end
      tests++;
      if (bus.r_valid !== (c == 4)) begin
        fails++;
        $display("FAIL first_read_valid c=%0d: got %b required %b", c, bus.r_valid, (c == 4));
      end
      if (c == 4) begin
        tests++;
        if (bus.r_data !== 16'h00FF) begin
          fails++;
          $display("FAIL first_read_data: got %h required 00ff", bus.r_data);
        end
      end
    end
  endtask

  task automatic test_write();
    for (int c = 0; c < 4; c++) begin
      start_cycle();
      clear_inputs();
      if (c == 0) begin
        bus.w_en   = 1'b1;
        bus.w_data = 16'hA5C3;
      end else begin
        bus.w_data = 16'hFFFF;
      end
      settle();
      tests++;
      if (dut.r_oe !== (c == 1)) begin
        fails++;
        $display("FAIL write_oe c=%0d: got %b required %b", c, dut.r_oe, (c == 1));
      end
      if (c == 1) begin
        tests++;
        if (dq !== 16'hA5C3) begin
          fails++;
          $display("FAIL write_dq: got %h required a5c3", dq);
        end
      end
    end
  endtask

  task automatic test_read_single();
    for (int c = 0; c < 8; c++) begin
      start_cycle();
      clear_inputs();
      bus.cas_latency = 2'd3;
      bus.rd_issue    = (c == 0);
      if (c == 4) begin
        dev_oe   = 1'b1;
        dev_data = 16'h1234;
      end
      settle();
      tests++;
      if (bus.r_valid !== (c == 5)) begin
        fails++;
        $display("FAIL cl3_valid c=%0d: got %b required %b", c, bus.r_valid, (c == 5));
      end
      tests++;
      if (bus.rd_busy !== (c <= 5)) begin
        fails++;
        $display("FAIL cl3_busy c=%0d: got %b required %b", c, bus.rd_busy, (c <= 5));
      end
      if (c >= 5) begin
        tests++;
        if (bus.r_data !== 16'h1234) begin
          fails++;
          $display("FAIL cl3_data c=%0d: got %h required 1234", c, bus.r_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pat [8];
    pat = '{16'hA001, 16'hB102, 16'hC203, 16'hD304, 16'hE405, 16'hF506, 16'h0607, 16'h1708};
    for (int c = 0; c < 14; c++) begin
      start_cycle();
      clear_inputs();
      bus.cas_latency = 2'd2;
      bus.rd_issue    = (c <= 7);
      if (c >= 3 && c <= 10) begin
        dev_oe   = 1'b1;
        dev_data = pat[c-3];
      end
      settle();
      tests++;
      if (bus.r_valid !== (c >= 4 && c <= 11)) begin
        fails++;
        $display("FAIL b2b_valid c=%0d: got %b required %b", c, bus.r_valid, (c >= 4 && c <= 11));
      end
      tests++;
      if (bus.rd_busy !== (c <= 11)) begin
        fails++;
        $display("FAIL b2b_busy c=%0d: got %b required %b", c, bus.rd_busy, (c <= 11));
      end
      if (c >= 4 && c <= 11) begin
        tests++;
        if (bus.r_data !== pat[c-4]) begin
          fails++;
          $display("FAIL b2b_data c=%0d: got %h required %h", c, bus.r_data, pat[c-4]);
        end
      end
    end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 8; c++) begin
      start_cycle();
      clear_inputs();
      bus.rd_issue = (c == 0);
      if (c == 2) begin
        bus.w_en   = 1'b1;
        bus.w_data = 16'hDEAD;
      end
      if (c == 5) begin
        bus.w_en   = 1'b1;
        bus.w_data = 16'h1111;
      end
      if (c == 3) begin
        dev_oe   = 1'b1;
        dev_data = 16'h5A5A;
      end
      settle();
      tests++;
      if (bus.err_contention !== (c == 3)) begin
        fails++;
        $display("FAIL cont_err c=%0d: got %b required %b", c, bus.err_contention, (c == 3));
      end
      tests++;
      if (dut.r_oe !== (c == 6)) begin
        fails++;
        $display("FAIL cont_oe c=%0d: got %b required %b", c, dut.r_oe, (c == 6));
      end
      tests++;
      if (bus.r_valid !== (c == 4)) begin
        fails++;
        $display("FAIL cont_valid c=%0d: got %b required %b", c, bus.r_valid, (c == 4));
      end
      if (c == 4) begin
        tests++;
        if (bus.r_data !== 16'h5A5A) begin
          fails++;
          $display("FAIL cont_data: got %h required 5a5a", bus.r_data);
        end
      end
      if (c == 6) begin
        tests++;
        if (dq !== 16'h1111) begin
          fails++;
          $display("FAIL cont_write_after: got %h required 1111", dq);
        end
      end
    end
  endtask

  task automatic test_merge_and_clamp();
    // Pass 0: CL3 then CL2 converge; pass 1: latency 1 behaves as CL_MAX
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 9; c++) begin
        start_cycle();
        clear_inputs();
        if (p == 0) begin
          bus.rd_issue    = (c <= 1);
          bus.cas_latency = (c == 0) ? 2'd3 : 2'd2;
        end else begin
          bus.rd_issue    = (c == 0);
          bus.cas_latency = 2'd1;
        end
        if (c == 4) begin
          dev_oe   = 1'b1;
          dev_data = (p == 0) ? 16'h7777 : 16'h3C3C;
        end
        settle();
        tests++;
        if (bus.r_valid !== (c == 5)) begin
          fails++;
          $display("FAIL merge_clamp_valid p=%0d c=%0d: got %b required %b",
                   p, c, bus.r_valid, (c == 5));
        end
        if (c == 5) begin
          tests++;
          if (bus.r_data !== ((p == 0) ? 16'h7777 : 16'h3C3C)) begin
            fails++;
            $display("FAIL merge_clamp_data p=%0d: got %h required %h",
                     p, bus.r_data, ((p == 0) ? 16'h7777 : 16'h3C3C));
          end
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    for (int c = 0; c < 11; c++) begin
      start_cycle();
      clear_inputs();
      bus.cas_latency = 2'd3;
      bus.rd_issue    = (c <= 1);
      if (c == 1) begin
        bus.w_en   = 1'b1;
        bus.w_data = 16'hBEEF;
      end
      if (c == 2) begin
        tests++;
        if (dut.r_oe !== 1'b1 || dq !== 16'hBEEF) begin
          fails++;
          $display("FAIL midrst_pre: got oe=%b dq=%h required oe=1 dq=beef", dut.r_oe, dq);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (dut.r_oe !== 1'b0 || bus.rd_busy !== 1'b0) begin
          fails++;
          $display("FAIL midrst_async: got oe=%b busy=%b required oe=0 busy=0",
                   dut.r_oe, bus.rd_busy);
        end
      end
      if (c == 4) begin
        rst_n = 1'b1;
      end
      settle();
      tests++;
      if (bus.r_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst_valid c=%0d: got %b required 0", c, bus.r_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_single();
    test_back_to_back();
    test_contention();
    test_merge_and_clamp();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
